// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default oversample ratio, divider helper
// and the phase encoding used by the receive one-shot guards.
package uart_pkg;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_START = 2'd1,
    PH_DATA  = 2'd2,
    PH_COMP  = 2'd3
  } phase_e;

  // Rounded clock divider for one oversample tick.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned osr);
    return (clk_hz + (baud * osr) / 2) / (baud * osr);
  endfunction

  // Collapse the FSM strobes into one phase; compare outranks data.
  function automatic phase_e phase_of(input logic s_count,
                                      input logic s_date,
                                      input logic s_comp);
    phase_e ph;
    if (!s_count)     ph = PH_IDLE;
    else if (s_comp)  ph = PH_COMP;
    else if (s_date)  ph = PH_DATA;
    else              ph = PH_START;
    return ph;
  endfunction

endpackage

// File: rtl/uart_rx_datapath_if.sv
// Link between the receive datapath, its control FSM and the byte consumer.
interface uart_rx_datapath_if;
  import uart_pkg::*;

  logic                 Rx;
  logic                 s_count;
  logic                 s_Date;
  logic                 s_comp;
  logic                 tick;
  logic                 Check;
  logic                 done;
  logic [DATA_BITS-1:0] data;
  logic                 match;
  logic                 frame_err;

  modport slave (
    input  Rx, s_count, s_Date, s_comp,
    output tick, Check, done, data, match, frame_err
  );

  modport master (
    output Rx, s_count, s_Date, s_comp,
    input  tick, Check, done, data, match, frame_err
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Oversample timebase: counts 0..DIV-1 while enabled, registered one-cycle ost on wrap.
module uart_baud_gen #(
  parameter int unsigned DIV = 326
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic ost_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ost_q, ost_d;

  always_comb begin
    cnt_d = cnt_q;
    ost_d = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d = '0;
      ost_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ost_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ost_q <= ost_d;
    end
  end

  assign ost_o = ost_q;

endmodule

// File: rtl/uart_rx_datapath.sv
// UART receive datapath: Rx synchroniser, oversample sampling of start/data/stop
// bits, byte assembly and the tick/Check/done events for the control FSM.
module uart_rx_datapath
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter logic [7:0]  MATCH_BYTE = 8'h7E
) (
  input  logic               clk,
  input  logic               reset,
  uart_rx_datapath_if.slave  bus
);

  localparam int unsigned DIV  = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SC_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(DATA_BITS);

  logic [1:0]           sync_q, sync_d;
  logic [SC_W-1:0]      sc_q, sc_d;
  logic [BC_W-1:0]      bc_q, bc_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 start_bad_q, start_bad_d;
  logic                 fired_tick_q, fired_tick_d;
  logic                 fired_chk_q, fired_chk_d;
  logic                 fired_done_q, fired_done_d;
  logic                 tick_q, tick_d;
  logic                 check_q, check_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 match_q, match_d;
  logic                 ferr_q, ferr_d;

  logic   ost;
  logic   rx_s;
  logic   frame_bad_c;
  phase_e phase;

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (bus.s_count),
    .ost_o (ost)
  );

  assign rx_s        = sync_q[1];
  assign phase       = phase_of(bus.s_count, bus.s_Date, bus.s_comp);
  assign frame_bad_c = start_bad_q | ~rx_s;

  // Each event fires once per phase visit; leaving the phase re-arms it.
  always_comb begin
    sync_d       = {sync_q[0], bus.Rx};
    sc_d         = sc_q;
    bc_d         = bc_q;
    shreg_d      = shreg_q;
    start_bad_d  = start_bad_q;
    fired_tick_d = fired_tick_q & (phase == PH_START);
    fired_chk_d  = fired_chk_q  & (phase == PH_DATA);
    fired_done_d = fired_done_q & (phase == PH_COMP);
    tick_d       = 1'b0;
    check_d      = 1'b0;
    done_d       = 1'b0;
    data_d       = data_q;
    match_d      = match_q;
    ferr_d       = ferr_q;

    if (ost) sc_d = sc_q + SC_W'(1);

    unique case (phase)
      PH_START: begin
        if (ost && sc_q == SC_W'(OVERSAMPLE / 2 - 1) && !fired_tick_q) begin
          tick_d       = 1'b1;
          fired_tick_d = 1'b1;
          sc_d         = '0;
          start_bad_d  = start_bad_q | rx_s;
        end
      end
      PH_DATA: begin
        if (ost && sc_q == SC_W'(OVERSAMPLE - 1) && !fired_chk_q) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          bc_d    = bc_q + BC_W'(1);
          sc_d    = '0;
          if (bc_q == BC_W'(DATA_BITS - 1)) begin
            check_d     = 1'b1;
            fired_chk_d = 1'b1;
          end
        end
      end
      PH_COMP: begin
        if (ost && sc_q == SC_W'(OVERSAMPLE - 1) && !fired_done_q) begin
          data_d       = shreg_q;
          ferr_d       = frame_bad_c;
          match_d      = (shreg_q == MATCH_BYTE) & ~frame_bad_c;
          done_d       = 1'b1;
          fired_done_d = 1'b1;
        end
      end
      default: begin
        sc_d        = '0;
        bc_d        = '0;
        start_bad_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= 2'b11;
      sc_q         <= '0;
      bc_q         <= '0;
      shreg_q      <= '0;
      start_bad_q  <= 1'b0;
      fired_tick_q <= 1'b0;
      fired_chk_q  <= 1'b0;
      fired_done_q <= 1'b0;
      tick_q       <= 1'b0;
      check_q      <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= '0;
      match_q      <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      sc_q         <= sc_d;
      bc_q         <= bc_d;
      shreg_q      <= shreg_d;
      start_bad_q  <= start_bad_d;
      fired_tick_q <= fired_tick_d;
      fired_chk_q  <= fired_chk_d;
      fired_done_q <= fired_done_d;
      tick_q       <= tick_d;
      check_q      <= check_d;
      done_q       <= done_d;
      data_q       <= data_d;
      match_q      <= match_d;
      ferr_q       <= ferr_d;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.Check     = check_q;
  assign bus.done      = done_q;
  assign bus.data      = data_q;
  assign bus.match     = match_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Bench for uart_rx_datapath with a behavioural receive control FSM and a
// scoreboard of expected byte/match/framing results per frame.
module tb_uart_rx_datapath;

  localparam int unsigned BIT_CYC = 160;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_rx_datapath_if bus();

  uart_rx_datapath #(
    .CLK_HZ     (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16),
    .MATCH_BYTE (8'h7E)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Control FSM: idle until Rx falls, then start -> data -> compare on the events.
  typedef enum logic [1:0] {F_IDLE, F_START, F_DATA, F_COMP} fsm_e;
  fsm_e fst;

  always @(posedge clk or negedge reset) begin
    if (!reset) fst <= F_IDLE;
    else begin
      case (fst)
        F_IDLE:  if (!bus.Rx)    fst <= F_START;
        F_START: if (bus.tick)   fst <= F_DATA;
        F_DATA:  if (bus.Check)  fst <= F_COMP;
        F_COMP:  if (bus.done)   fst <= F_IDLE;
        default:                 fst <= F_IDLE;
      endcase
    end
  end

  assign bus.s_count = (fst != F_IDLE);
  assign bus.s_Date  = (fst == F_DATA);
  assign bus.s_comp  = (fst == F_COMP);

  typedef struct packed {
    logic [7:0] data;
    logic       match;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   t_start, t_tick, t_chk;
  logic prev_sc, prev_tick, prev_chk, prev_done, pend;

  // Event monitor: pulse width/placement, event spacing, scoreboard pop after done.
  always @(negedge clk) begin
    if (!reset) begin
      prev_sc   <= 1'b0;
      prev_tick <= 1'b0;
      prev_chk  <= 1'b0;
      prev_done <= 1'b0;
      pend      <= 1'b0;
    end else begin
      if (pend) begin
        if (sb.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
        else begin
          check_eq("data",      32'(bus.data),      32'(sb[0].data));
          check_eq("match",     32'(bus.match),     32'(sb[0].match));
          check_eq("frame_err", 32'(bus.frame_err), 32'(sb[0].ferr));
          void'(sb.pop_front());
        end
      end
      if (bus.s_count && !prev_sc) t_start <= cyc;
      if (bus.tick) begin
        check_eq("tick_width", 32'(prev_tick), 32'd0);
        check_eq("tick_in_frame", 32'(bus.s_count), 32'd1);
        check_eq("tick_latency_ok", 32'((cyc - t_start) >= 79 && (cyc - t_start) <= 81), 32'd1);
        t_tick <= cyc;
      end
      if (bus.Check) begin
        check_eq("check_width", 32'(prev_chk), 32'd0);
        check_eq("check_in_frame", 32'(bus.s_count), 32'd1);
        check_eq("check_spacing_ok", 32'((cyc - t_tick) >= 1279 && (cyc - t_tick) <= 1281), 32'd1);
        t_chk <= cyc;
      end
      if (bus.done) begin
        check_eq("done_width", 32'(prev_done), 32'd0);
        check_eq("done_in_frame", 32'(bus.s_count), 32'd1);
        check_eq("done_spacing_ok", 32'((cyc - t_chk) >= 159 && (cyc - t_chk) <= 161), 32'd1);
      end
      pend      <= bus.done;
      prev_sc   <= bus.s_count;
      prev_tick <= bus.tick;
      prev_chk  <= bus.Check;
      prev_done <= bus.done;
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", 32'(bus.done), 32'd1);
  endtask

  // Drives one frame; releases the line as soon as done so a low stop bit cannot retrigger.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int idle_bits);
    exp_t e;
    e.data  = b;
    e.ferr  = ~stop;
    e.match = (b == 8'h7E) && stop;
    sb.push_back(e);
    bus.Rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.Rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    bus.Rx = stop;
    wait_done(2 * BIT_CYC);
    bus.Rx = 1'b1;
    repeat (BIT_CYC / 2 + idle_bits * BIT_CYC) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"},  32'(bus.data),      32'd0);
    check_eq({tag, "_match"}, 32'(bus.match),     32'd0);
    check_eq({tag, "_ferr"},  32'(bus.frame_err), 32'd0);
    check_eq({tag, "_tick"},  32'(bus.tick),      32'd0);
    check_eq({tag, "_check"}, 32'(bus.Check),     32'd0);
    check_eq({tag, "_done"},  32'(bus.done),      32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    exp_t       e;
    bus.Rx = 1'b1;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'h7E, 1'b1, 2);
    send_frame(8'hA5, 1'b1, 2);
    send_frame(8'h7E, 1'b0, 2);
    check_eq("fsm_idle_after_bad_stop", 32'(bus.s_count), 32'd0);

    // Start glitch: the line returns high, so every sampled bit reads 1.
    e.data = 8'hFF; e.match = 1'b0; e.ferr = 1'b1;
    sb.push_back(e);
    bus.Rx = 1'b0;
    repeat (30) @(negedge clk);
    bus.Rx = 1'b1;
    wait_done(2000);
    repeat (2 * BIT_CYC) @(negedge clk);

    // Reset in the middle of the 4th data bit of a 0x7E frame.
    rb = 8'h7E;
    bus.Rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.Rx = rb[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    bus.Rx = rb[3];
    repeat (BIT_CYC / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    bus.Rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'h7E, 1'b1, 2);
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h7E, 1'b1, 2);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_datapath.md
# uart_rx_datapath

Receive datapath for the XBee serial link, paired with the receive control FSM. It synchronises `Rx`, generates the oversample timebase, samples the start, data and stop bits, and assembles the received byte. It returns the `tick`, `Check` and `done` events that advance the FSM, and it is driven by that FSM's `s_count`, `s_Date` and `s_comp` phase strobes. It also presents the byte, a match flag and a framing error to the downstream consumer.

## Interface

- `CLK_HZ`, 50_000_000, system clock frequency (Nexys2 board clock).
- `BAUD`, 9600, line rate.
- `OVERSAMPLE`, 16, oversample ticks per bit; must be even and ≥ 8.
- `MATCH_BYTE`, 8'h7E, byte compared against in the compare phase.
- `clk  in  1`  system clock; all logic on the rising edge.
- `reset  in  1`  asynchronous, active-low reset.
- `Rx  in  1`  raw serial line; idle high.
- `s_count  in  1`  FSM strobe: a frame is in progress and the counters run.
- `s_Date  in  1`  FSM strobe: data-bit phase.
- `s_comp  in  1`  FSM strobe: stop/compare phase.
- `tick  out  1`  one-cycle pulse at the start-bit midpoint.
- `Check  out  1`  one-cycle pulse after the 8th data bit has been sampled.
- `done  out  1`  one-cycle pulse when the stop bit has been sampled and the results are updated.
- `data  out  8`  last received byte, LSB first on the wire.
- `match  out  1`  last byte equals `MATCH_BYTE` and had no framing error.
- `frame_err  out  1`  last frame had a bad start midpoint or a low stop bit.

## Operation

- **Rx synchroniser:** 2-flop; both flops reset to 1. All sampling uses the synchronised value `rx_s`.
- **Divider:** `DIV = round(CLK_HZ / (BAUD*OVERSAMPLE))`; 326 at the default values.
  - Divider counter `0..DIV-1` runs only while `s_count=1`.
  - `ost` pulses for one cycle when the counter wraps.
  - When `s_count=0`, the counter is held at 0.
- **Sample counter `sc`:** counts `ost` events. Bit counter `bc` is 0..7.
- **Start phase** (`s_count & ~s_Date & ~s_comp`):
  - At `sc == OVERSAMPLE/2 - 1` with `ost`, pulse `tick` and clear `sc`.
  - If `rx_s == 1` at that point, set an internal `start_bad` flag. `tick` still fires, so the FSM cannot hang.
- **Data phase** (`s_Date`):
  - At `sc == OVERSAMPLE-1` with `ost`, shift `rx_s` into `shreg[7]` (right shift), increment `bc` and clear `sc`.
  - On the sample where `bc == 7`, pulse `Check`.
  - `sc` keeps counting into the compare phase without being cleared.
- **Compare phase** (`s_comp`): at the next `sc == OVERSAMPLE-1` with `ost`, sample the stop bit and update, all in the same cycle:
  - `data <= shreg`
  - `frame_err <= start_bad | ~rx_s`
  - `match <= (shreg == MATCH_BYTE) & ~(start_bad | ~rx_s)`
  - pulse `done`
- **Pulse guards:** an `armed` flag per event prevents a re-pulse while the FSM is still in the same phase. The FSM's strobes are combinational from its state register and change one cycle after each pulse.
- **Abort:** if `s_count` falls mid-frame, clear `sc`, `bc`, the divider, `start_bad` and the armed flags. `data`, `match` and `frame_err` keep their last values.
- **Reset values:** `tick=0`, `Check=0`, `done=0`, `data=8'h00`, `match=0`, `frame_err=0`; internal counters 0.
- **Async reset:** takes effect immediately at any point in a frame; no partial results are published.

## Timing

- **Rx latency:** 2 cycles of synchroniser delay; the FSM sees the falling edge on `Rx` directly.
- **`tick` timing:** (OVERSAMPLE/2)·DIV cycles (±1) after `s_count` rises.
- **Data bit sampling:** each data bit is sampled OVERSAMPLE·DIV cycles after the previous sample point. `Check` coincides with the 8th sample.
- **Stop bit:** `done` occurs one bit period after `Check`. `data`, `match` and `frame_err` are valid from the cycle after `done` and hold until the next `done`.
- **Pulse width:** `tick`, `Check` and `done` are registered and exactly one cycle wide. They are never asserted while `s_count=0`.
- **Simultaneous events:**
  - `s_count` falling on the same cycle as an `ost`: the abort wins and no pulse is issued.
  - Reset asserted on the same cycle as `done`: all outputs go to their reset values.

## Structure

- **Package `uart_pkg`:**
  - `DATA_BITS=8`
  - default `OVERSAMPLE`
  - a constant function `baud_div(clk_hz, baud, osr)` shared with the transmit side
  - the phase encoding used by the armed flags
- **Sub-module `uart_baud_gen`:** the divider plus `ost` output with an enable input. It is reused by the transmitter.

## Test plan

All scenarios use `CLK_HZ=1_600_000`, `BAUD=10_000`, `OVERSAMPLE=16` (DIV=10, 160 cycles per bit), with the real control FSM connected.

- **Clean matching byte:** send 0x7E with a good stop bit. Expect `tick` about 80 cycles after `s_count` rises, `Check` about 1280 cycles later, then `done`; `data=0x7E`, `match=1`, `frame_err=0`.
- **Clean non-matching byte:** send 0xA5. Expect `data=0xA5`, `match=0`, `frame_err=0`.
- **Bad stop bit:** send 0x7E with the stop bit driven low. Expect `data=0x7E`, `frame_err=1`, `match=0`, and the FSM back in idle after `done`.
- **Start glitch:** pulse `Rx` low for 30 cycles. Expect `tick` to still fire, the frame to complete, and `frame_err=1`.
- **Async reset mid-frame:** assert reset in the middle of the 4th data bit. Expect all outputs at their reset values immediately; a following clean 0x7E frame must then receive correctly.
- **Back-to-back frames:** send 0x11 then 0x7E with one idle bit between them. Expect two `done` pulses with `data` reading 0x11 then 0x7E, and `match` going 0 then 1.
